alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_ctrl_pkg.sv | 52 +++++
 rtl/cmd_fifo2.sv | 57 +++++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Opcodes, flag positions, sequencer states and command layout.
// Revision : 1.0
// ============================================================================
package alu_ctrl_pkg;

    localparam int OP_W       = 4;
    localparam int REG_W      = 4;
    localparam int REP_W      = 4;
    localparam int FLAG_W     = 5;
    localparam int FIFO_DEPTH = 2;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_SHL = 4'h5;
    localparam logic [OP_W-1:0] OP_SHR = 4'h6;
    localparam logic [OP_W-1:0] OP_CMP = 4'h7;

    // Flag vector layout is {C,L,F,Z,N}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 3;
    localparam int FLAG_C = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rd;
        logic [REP_W-1:0] rep;
    } cmd_t;

    // Compares only update flags; every other opcode writes back a result
    function automatic logic writes_back(input logic [OP_W-1:0] op);
        return op != OP_CMP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo2
// Brief    : Two-entry command FIFO with wrapping pointers and occupancy count.
// Revision : 1.0
// ============================================================================
module cmd_fifo2
    import alu_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_full,
    output logic o_empty
);

    cmd_t       r_mem [FIFO_DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_full  = (r_count == 2'(FIFO_DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            // Simultaneous push and pop leaves occupancy unchanged
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Buffers ALU commands and steps each through READ/EXEC/WRITE,
//            repeating it cmd_rep+1 times.
// Revision : 1.0
// ============================================================================
module alu_sequencer
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_W-1:0]  cmd_ra,
    input  logic [REG_W-1:0]  cmd_rb,
    input  logic [REG_W-1:0]  cmd_rd,
    input  logic [REP_W-1:0]  cmd_rep,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [REG_W-1:0]  ra_addr,
    output logic [REG_W-1:0]  rb_addr,
    output logic [OP_W-1:0]   alu_op,
    output logic [REG_W-1:0]  wr_addr,
    output logic              wr_en,
    output logic [FLAG_W-1:0] flags,
    output logic              busy,
    output logic              done
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    cmd_t              r_cmd;
    logic [REP_W-1:0]  r_iter;
    logic [FLAG_W-1:0] r_flags;

    cmd_t w_cmd_in;
    cmd_t w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_dec;

    assign w_cmd_in  = '{op: cmd_op, ra: cmd_ra, rb: cmd_rb, rd: cmd_rd, rep: cmd_rep};
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & cmd_ready;

    cmd_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_iter  <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_cmd  <= w_head;
                r_iter <= w_head.rep;
            end else if (w_dec) begin
                r_iter <= r_iter - 1'b1;
            end
            if (r_state == ST_WRITE) begin
                r_flags <= alu_flags;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_READ;
                    w_pop       = 1'b1;
                end
            end
            ST_READ:  w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                // Remaining iterations take priority over the next buffered command
                if (r_iter != '0) begin
                    w_state_nxt = ST_READ;
                    w_dec       = 1'b1;
                end else if (!w_empty) begin
                    w_state_nxt = ST_READ;
                    w_pop       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ra_addr = '0;
        rb_addr = '0;
        alu_op  = '0;
        wr_addr = '0;
        wr_en   = 1'b0;
        done    = 1'b0;
        if (r_state != ST_IDLE) begin
            ra_addr = r_cmd.ra;
            rb_addr = r_cmd.rb;
            alu_op  = r_cmd.op;
            wr_addr = r_cmd.rd;
        end
        if (r_state == ST_WRITE) begin
            wr_en = writes_back(r_cmd.op);
            done  = (r_iter == '0);
        end
    end

    assign flags = r_flags;
    assign busy  = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire
